spi_master_multi: RTL and testbench
===================================

Name: spi_master_multi

Overview:
- Parametrised SPI master for on-chip peripheral access: configurable word width, SCLK divider and chip-select count.
- CPOL/CPHA mode and bit order are chosen per transfer, not fixed at build time.
- Sits between a register/control block (start/busy/done handshake) and up to NUM_CS external SPI slaves sharing SCLK/MOSI/MISO.

Parameters:
DATA_W, 8, bits per transfer (>=2)
NUM_CS, 4, number of chip-select lines (>=1)
CLK_DIV, 4, clk cycles per SCLK half-period (>=1); SCLK = clk/(2*CLK_DIV)
CS_W, $clog2(NUM_CS) min 1, width of cs_sel (derived, not overridden)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  transfer request, sampled only in IDLE
cpol  in  1  SCLK idle level, latched on accepted start
cpha  in  1  0: sample on leading edge; 1: drive on leading, sample on trailing; latched on accepted start
lsb_first  in  1  1: LSB shifted first; latched on accepted start
cs_sel  in  CS_W  target slave index, latched on accepted start
tx_data  in  DATA_W  word to send, latched on accepted start
rx_data  out  DATA_W  last received word, in natural bit order
busy  out  1  high while a transfer is in progress
done  out  1  one-cycle pulse at end of transfer
spi_sclk  out  1  SPI clock
spi_mosi  out  1  serial data out
spi_miso  in  1  serial data in
spi_cs_n  out  NUM_CS  active-low chip selects, one-hot-low during transfer

Behaviour:
- Reset (rst_n low, immediate): state IDLE, spi_sclk=0, spi_mosi=0, spi_cs_n all 1, busy=0, done=0, rx_data=0, counters 0.
- FSM: IDLE -> LEAD -> SHIFT -> TRAIL -> IDLE.
- IDLE:
  - spi_sclk = latched cpol (0 after reset); spi_mosi=0; CS all high.
  - Start accepted when start=1 in IDLE: tx_data, cpol, cpha, lsb_first and cs_sel are latched; next cycle enters LEAD with busy=1.
- LEAD, CLK_DIV cycles:
  - spi_cs_n[cs_sel] low.
  - spi_mosi = first bit (tx[DATA_W-1], or tx[0] if lsb_first) in both modes; SCLK stays idle.
- SHIFT, 2*DATA_W*CLK_DIV cycles:
  - SCLK toggles every CLK_DIV cycles, giving 2*DATA_W edges. Odd edges are leading, even edges trailing.
  - cpha=0: MISO sampled on leading edges; MOSI advances to the next bit on trailing edges, except the last.
  - cpha=1: MOSI advances on leading edges, except the first (the first bit is already driven from LEAD); MISO sampled on trailing edges.
  - Sampling is done in the clk cycle in which the SCLK register toggles, using the pre-toggle MISO value.
- TRAIL, CLK_DIV cycles: SCLK back at cpol, CS still asserted, MOSI holds the last bit.
- Exit from TRAIL, one cycle:
  - state=IDLE, CS deasserted, busy=0.
  - done=1 for exactly this cycle; rx_data updated in the same cycle.
  - rx_data holds until the next done.
- Start handling:
  - A start in the done cycle is accepted (back-to-back).
  - Start while busy is ignored; no queueing.
- Total latency: accepted start at cycle 0 -> done at cycle 1 + (2*DATA_W+2)*CLK_DIV.
- Out-of-range cs_sel (>= NUM_CS): transfer runs with full timing, all CS stay high, and rx_data still updates.
- lsb_first=1: bits are sent tx[0] first; received bits are reassembled so that the first sampled bit lands in rx_data[0].
- Input changes while busy have no effect on the current transfer.
- Reset mid-transfer: all outputs return to reset values asynchronously, no done pulse, rx_data cleared.

Test Plan:
- Mode 0, DATA_W=8, CLK_DIV=2, MOSI looped to MISO, tx_data=0xA5, cs_sel=1 -> only spi_cs_n[1] low, 16 SCLK edges, done at cycle 37 after start, rx_data=0xA5.
- Mode 3 (cpol=1, cpha=1), slave model returns 0x3C, tx_data=0xC3 -> SCLK idles 1; slave captures 0xC3; rx_data=0x3C; MOSI changes only on falling SCLK edges.
- lsb_first=1, tx_data=0x01, loopback -> first MOSI bit in LEAD is 1, rest 0; rx_data=0x01.
- start pulsed again at cycles 5 and 20 of a transfer, then in the done cycle -> first two ignored; second transfer's LEAD starts the cycle after done; busy stays high except in the done cycle.
- cs_sel=3 with NUM_CS=3 -> all spi_cs_n=1 for the whole transfer, done still pulses at the normal time.
- rst_n low during SHIFT -> CS high, sclk=0, busy=0 immediately; no done; next start runs a clean transfer.

Source files
------------

// File: rtl/spi_master_multi.sv
// ============================================================================
// Module   : spi_master_multi
// Brief    : SPI master with per-transfer CPOL/CPHA/bit order and NUM_CS selects
// Revision : 1.0
// ============================================================================
`default_nettype none

module spi_master_multi #(
    parameter int DATA_W  = 8,
    parameter int NUM_CS  = 4,
    parameter int CLK_DIV = 4,
    parameter int CS_W    = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic [DATA_W-1:0] tx_data,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              done,
    output logic              spi_sclk,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic [NUM_CS-1:0] spi_cs_n
);

    localparam int c_CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_EDGE_W = $clog2(2 * DATA_W);
    localparam logic [c_CNT_W-1:0]  c_CNT_MAX   = c_CNT_W'(CLK_DIV - 1);
    localparam logic [c_EDGE_W-1:0] c_EDGE_LAST = c_EDGE_W'(2 * DATA_W - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_LEAD  = 2'd1;
    localparam logic [1:0] c_SHIFT = 2'd2;
    localparam logic [1:0] c_TRAIL = 2'd3;

    logic [1:0]          r_state;
    logic [1:0]          w_next;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_EDGE_W-1:0] r_edge;
    logic                r_sclk;
    logic                r_cpol;
    logic                r_cpha;
    logic                r_lsb;
    logic [CS_W-1:0]     r_cs;
    logic [DATA_W-1:0]   r_tx;
    logic [DATA_W-1:0]   r_rx_sh;
    logic [DATA_W-1:0]   r_rx;
    logic                r_done;

    logic w_accept;
    logic w_half_end;
    logic w_toggle;
    logic w_leading;
    logic w_sample;
    logic w_advance;

    assign w_accept   = (r_state == c_IDLE) && start;
    assign w_half_end = (r_cnt == c_CNT_MAX);
    assign w_toggle   = (r_state == c_SHIFT) && w_half_end;
    // Edge numbers are 1-based, so an even r_edge means the next edge is a leading one
    assign w_leading  = ~r_edge[0];
    assign w_sample   = w_toggle && (r_cpha ? ~w_leading : w_leading);
    assign w_advance  = w_toggle && (r_cpha ? (w_leading && (r_edge != '0))
                                            : (~w_leading && (r_edge != c_EDGE_LAST)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:  if (start) w_next = c_LEAD;
            c_LEAD:  if (w_half_end) w_next = c_SHIFT;
            c_SHIFT: if (w_half_end && (r_edge == c_EDGE_LAST)) w_next = c_TRAIL;
            c_TRAIL: if (w_half_end) w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    always_comb begin
        busy     = (r_state != c_IDLE);
        done     = r_done;
        rx_data  = r_rx;
        spi_sclk = (r_state == c_SHIFT) ? r_sclk : r_cpol;
        spi_mosi = 1'b0;
        spi_cs_n = '1;
        if (r_state != c_IDLE) begin
            spi_mosi = r_lsb ? r_tx[0] : r_tx[DATA_W-1];
            // Out-of-range selects simply match no line
            for (int i = 0; i < NUM_CS; i++) begin
                if (r_cs == CS_W'(i)) spi_cs_n[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_edge  <= '0;
            r_sclk  <= 1'b0;
            r_cpol  <= 1'b0;
            r_cpha  <= 1'b0;
            r_lsb   <= 1'b0;
            r_cs    <= '0;
            r_tx    <= '0;
            r_rx_sh <= '0;
            r_rx    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= (r_state == c_TRAIL) && w_half_end;

            if (r_state == c_IDLE) begin
                r_cnt <= '0;
            end else if (w_half_end) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end

            if (w_accept) begin
                r_tx   <= tx_data;
                r_cpol <= cpol;
                r_cpha <= cpha;
                r_lsb  <= lsb_first;
                r_cs   <= cs_sel;
                r_sclk <= cpol;
                r_edge <= '0;
            end

            if (w_toggle) begin
                r_sclk <= ~r_sclk;
                r_edge <= (r_edge == c_EDGE_LAST) ? '0 : r_edge + c_EDGE_W'(1);
            end

            if (w_advance) begin
                r_tx <= r_lsb ? {1'b0, r_tx[DATA_W-1:1]} : {r_tx[DATA_W-2:0], 1'b0};
            end

            // LSB-first shifts right so the first sampled bit ends up in bit 0
            if (w_sample) begin
                r_rx_sh <= r_lsb ? {spi_miso, r_rx_sh[DATA_W-1:1]}
                                 : {r_rx_sh[DATA_W-2:0], spi_miso};
            end

            if ((r_state == c_TRAIL) && w_half_end) begin
                r_rx <= r_rx_sh;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_spi_master_multi.sv
// ============================================================================
// Module   : tb_spi_master_multi
// Brief    : Scoreboard bench for spi_master_multi (DATA_W=8, NUM_CS=3, CLK_DIV=2)
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_spi_master_multi;

    localparam int DW  = 8;
    localparam int NCS = 3;
    localparam int DIV = 2;
    localparam int CSW = 2;
    localparam int LAT = 1 + (2 * DW + 2) * DIV;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           cpol = 1'b0;
    logic           cpha = 1'b0;
    logic           lsb_first = 1'b0;
    logic [CSW-1:0] cs_sel = '0;
    logic [DW-1:0]  tx_data = '0;
    logic [DW-1:0]  rx_data;
    logic           busy;
    logic           done;
    logic           spi_sclk;
    logic           spi_mosi;
    logic           spi_miso;
    logic [NCS-1:0] spi_cs_n;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_v;

    logic           loopback = 1'b1;
    logic           sl_cpol = 1'b0;
    logic           sl_cpha = 1'b0;
    logic           sl_miso = 1'b0;
    logic [7:0]     sl_tx = '0;
    logic [7:0]     sl_rx = '0;
    int             sl_idx = 0;
    logic           prev_cs_act = 1'b0;
    logic           prev_sclk = 1'b0;
    logic           prev_mosi = 1'b0;
    int             edge_cnt = 0;
    int             cs_bad = 0;
    int             mosi_bad = 0;
    logic [NCS-1:0] cs_exp = '1;

    wire cs_act = ~&spi_cs_n;
    assign spi_miso = loopback ? spi_mosi : sl_miso;

    always #5 clk = ~clk;

    spi_master_multi #(
        .DATA_W  (DW),
        .NUM_CS  (NCS),
        .CLK_DIV (DIV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .cpol      (cpol),
        .cpha      (cpha),
        .lsb_first (lsb_first),
        .cs_sel    (cs_sel),
        .tx_data   (tx_data),
        .rx_data   (rx_data),
        .busy      (busy),
        .done      (done),
        .spi_sclk  (spi_sclk),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .spi_cs_n  (spi_cs_n)
    );

    // Bus monitor and MSB-first slave model, sampled mid-cycle
    always @(negedge clk) begin
        logic lead;
        if (busy && spi_cs_n !== cs_exp) cs_bad++;
        if (cs_act && prev_cs_act) begin
            if (spi_sclk !== prev_sclk) edge_cnt++;
            if (spi_mosi !== prev_mosi && !(prev_sclk === 1'b1 && spi_sclk === 1'b0)) mosi_bad++;
        end
        if (!loopback) begin
            if (cs_act && !prev_cs_act) begin
                sl_idx = 0;
                sl_rx  = '0;
                if (!sl_cpha) sl_miso = sl_tx[7];
            end else if (cs_act && spi_sclk !== prev_sclk) begin
                lead = (spi_sclk != sl_cpol);
                if (lead != sl_cpha) begin
                    sl_rx = {sl_rx[6:0], spi_mosi};
                end else if (sl_cpha) begin
                    sl_miso = sl_tx[7-sl_idx];
                    sl_idx++;
                end else begin
                    sl_idx++;
                    if (sl_idx < 8) sl_miso = sl_tx[7-sl_idx];
                end
            end
        end
        prev_cs_act = cs_act;
        prev_sclk   = spi_sclk;
        prev_mosi   = spi_mosi;
    end

    task automatic launch(input logic [7:0] tx, input logic pol, input logic pha,
                          input logic lsb, input logic [CSW-1:0] cs,
                          input logic [7:0] exp_rx, input bit push);
        tx_data   = tx;
        cpol      = pol;
        cpha      = pha;
        lsb_first = lsb;
        cs_sel    = cs;
        start     = 1'b1;
        if (push) exp_q.push_back(exp_rx);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            start = 1'b0;
        end while (!done && n < 200);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({spi_sclk, spi_mosi, busy, done} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl sclk/mosi/busy/done got %b want 0000", {spi_sclk, spi_mosi, busy, done});
        end
        checks++;
        if (spi_cs_n !== 3'b111) begin
            errors++;
            $display("FAIL reset_cs got %b want 111", spi_cs_n);
        end
        checks++;
        if (rx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_rx got %h want 00", rx_data);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_mode0();
        int n;
        loopback = 1'b1; cs_exp = 3'b101; edge_cnt = 0; cs_bad = 0;
        launch(8'hA5, 1'b0, 1'b0, 1'b0, 2'd1, 8'hA5, 1'b1);
        wait_done(n);
        checks++;
        if (n !== LAT) begin
            errors++;
            $display("FAIL mode0_latency got %0d want %0d", n, LAT);
        end
        exp_v = exp_q.pop_front();
        checks++;
        if (rx_data !== exp_v) begin
            errors++;
            $display("FAIL mode0_rx got %h want %h", rx_data, exp_v);
        end
        checks++;
        if (edge_cnt !== 2 * DW) begin
            errors++;
            $display("FAIL mode0_edges got %0d want %0d", edge_cnt, 2 * DW);
        end
        checks++;
        if (cs_bad !== 0) begin
            errors++;
            $display("FAIL mode0_cs bad cycles got %0d want 0", cs_bad);
        end
        checks++;
        if ({busy, spi_cs_n} !== 4'b0111) begin
            errors++;
            $display("FAIL mode0_done_cycle busy/cs got %b want 0111", {busy, spi_cs_n});
        end
    endtask

    task automatic test_mode3();
        int n;
        loopback = 1'b0; sl_cpol = 1'b1; sl_cpha = 1'b1; sl_tx = 8'h3C;
        cs_exp = 3'b110; cs_bad = 0; mosi_bad = 0;
        launch(8'hC3, 1'b1, 1'b1, 1'b0, 2'd0, 8'h3C, 1'b1);
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (spi_sclk !== 1'b1) begin
            errors++;
            $display("FAIL mode3_lead_sclk got %b want 1", spi_sclk);
        end
        wait_done(n);
        checks++;
        if (n + 1 !== LAT) begin
            errors++;
            $display("FAIL mode3_latency got %0d want %0d", n + 1, LAT);
        end
        exp_v = exp_q.pop_front();
        checks++;
        if (rx_data !== exp_v) begin
            errors++;
            $display("FAIL mode3_rx got %h want %h", rx_data, exp_v);
        end
        checks++;
        if (sl_rx !== 8'hC3) begin
            errors++;
            $display("FAIL mode3_slave_rx got %h want c3", sl_rx);
        end
        checks++;
        if (mosi_bad !== 0) begin
            errors++;
            $display("FAIL mode3_mosi_edge bad changes got %0d want 0", mosi_bad);
        end
        checks++;
        if (spi_sclk !== 1'b1) begin
            errors++;
            $display("FAIL mode3_idle_sclk got %b want 1", spi_sclk);
        end
        checks++;
        if (cs_bad !== 0) begin
            errors++;
            $display("FAIL mode3_cs bad cycles got %0d want 0", cs_bad);
        end
    endtask

    task automatic test_lsb_first();
        int n;
        loopback = 1'b1; cs_exp = 3'b110;
        launch(8'h01, 1'b0, 1'b0, 1'b1, 2'd0, 8'h01, 1'b1);
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (spi_mosi !== 1'b1) begin
            errors++;
            $display("FAIL lsb_lead_mosi got %b want 1", spi_mosi);
        end
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (spi_mosi !== 1'b0) begin
            errors++;
            $display("FAIL lsb_second_bit got %b want 0", spi_mosi);
        end
        wait_done(n);
        checks++;
        if (n + 7 !== LAT) begin
            errors++;
            $display("FAIL lsb_latency got %0d want %0d", n + 7, LAT);
        end
        exp_v = exp_q.pop_front();
        checks++;
        if (rx_data !== exp_v) begin
            errors++;
            $display("FAIL lsb_rx got %h want %h", rx_data, exp_v);
        end
    endtask

    task automatic test_back_to_back();
        loopback = 1'b1; cs_exp = 3'b011; cs_bad = 0;
        launch(8'h5A, 1'b0, 1'b0, 1'b0, 2'd2, 8'h5A, 1'b1);
        for (int n = 1; n <= 2 * LAT; n++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (n == 5 || n == 20) begin
                tx_data = 8'hFF; cs_sel = 2'd0; cpol = 1'b1; start = 1'b1;
            end
            checks++;
            if (busy !== ((n % LAT) != 0)) begin
                errors++;
                $display("FAIL b2b_busy cycle %0d got %b want %b", n, busy, (n % LAT) != 0);
            end
            checks++;
            if (done !== ((n % LAT) == 0)) begin
                errors++;
                $display("FAIL b2b_done cycle %0d got %b want %b", n, done, (n % LAT) == 0);
            end
            if (done && exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                checks++;
                if (rx_data !== exp_v) begin
                    errors++;
                    $display("FAIL b2b_rx cycle %0d got %h want %h", n, rx_data, exp_v);
                end
            end
            if (n == LAT) launch(8'h96, 1'b0, 1'b0, 1'b0, 2'd2, 8'h96, 1'b1);
        end
        start = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_outstanding got %0d want 0", exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (cs_bad !== 0) begin
            errors++;
            $display("FAIL b2b_cs bad cycles got %0d want 0", cs_bad);
        end
    endtask

    task automatic test_cs_out_of_range();
        int n;
        loopback = 1'b1; cs_exp = 3'b111; cs_bad = 0;
        launch(8'h3E, 1'b0, 1'b0, 1'b0, 2'd3, 8'h3E, 1'b1);
        wait_done(n);
        checks++;
        if (n !== LAT) begin
            errors++;
            $display("FAIL oob_latency got %0d want %0d", n, LAT);
        end
        exp_v = exp_q.pop_front();
        checks++;
        if (rx_data !== exp_v) begin
            errors++;
            $display("FAIL oob_rx got %h want %h", rx_data, exp_v);
        end
        checks++;
        if (cs_bad !== 0) begin
            errors++;
            $display("FAIL oob_cs bad cycles got %0d want 0", cs_bad);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int stray;
        loopback = 1'b1; cs_exp = 3'b101;
        launch(8'h77, 1'b1, 1'b0, 1'b0, 2'd1, 8'h00, 1'b0);
        repeat (15) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({spi_sclk, spi_mosi, busy, done} !== 4'b0000) begin
            errors++;
            $display("FAIL midrst_ctrl sclk/mosi/busy/done got %b want 0000", {spi_sclk, spi_mosi, busy, done});
        end
        checks++;
        if (spi_cs_n !== 3'b111) begin
            errors++;
            $display("FAIL midrst_cs got %b want 111", spi_cs_n);
        end
        checks++;
        if (rx_data !== 8'h00) begin
            errors++;
            $display("FAIL midrst_rx got %h want 00", rx_data);
        end
        stray = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done) stray++;
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || busy) stray++;
        end
        checks++;
        if (stray !== 0) begin
            errors++;
            $display("FAIL midrst_stray done/busy cycles got %0d want 0", stray);
        end
        launch(8'hA5, 1'b0, 1'b0, 1'b0, 2'd1, 8'hA5, 1'b1);
        wait_done(n);
        checks++;
        if (n !== LAT) begin
            errors++;
            $display("FAIL midrst_after_latency got %0d want %0d", n, LAT);
        end
        exp_v = exp_q.pop_front();
        checks++;
        if (rx_data !== exp_v) begin
            errors++;
            $display("FAIL midrst_after_rx got %h want %h", rx_data, exp_v);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_mode0();
        test_mode3();
        test_lsb_first();
        test_back_to_back();
        test_cs_out_of_range();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
